mastermind_round_ctrl: RTL and testbench
========================================

Name: mastermind_round_ctrl

Overview:
- Sequences one Mastermind game: accepts a 4-peg guess from the input FSM, scores it against the secret over several cycles, and writes guess plus score into the guess-history store.
- Advances the guess number and declares win or lose.
- Sits between the debounced-button/core logic and the history matrix that the VGA renderer reads.

Parameters:
NUM_PEGS, 4, pegs per guess
COLOR_W, 3, bits per peg; code 0 = blank (invalid), legal colours 1..NUM_COLORS
NUM_COLORS, 6, number of legal colours
MAX_GUESSES, 6, guesses before loss

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse: begin or restart a game
secret  in  NUM_PEGS*COLOR_W  answer; sampled only on an accepted start
guess  in  NUM_PEGS*COLOR_W  candidate guess; peg i at bits [i*COLOR_W +: COLOR_W]
check_req  in  1  one-cycle pulse: submit guess
check_ack  out  1  pulse: guess accepted for scoring
check_rej  out  1  pulse: guess rejected
busy  out  1  scoring or writing in progress
guess_num  out  3  index of the current guess, 0..MAX_GUESSES-1
exact_cnt  out  3  pegs with right colour and right position (last score)
partial_cnt  out  3  pegs with right colour and wrong position (last score)
score_vld  out  1  pulse: exact_cnt/partial_cnt updated
hist_we  out  1  history write strobe
hist_waddr  out  3  history row (= guess_num of the scored guess)
hist_wdata  out  NUM_PEGS*COLOR_W+6  {partial, exact, guess}
game_active  out  1  high in READY or any scoring state
win  out  1  sticky until next start/reset
lose  out  1  sticky until next start/reset

Behaviour:
- Reset (asynchronous, active-low) clears all outputs and registers to 0; state goes to IDLE.
- States: IDLE, READY, EXACT, COUNT, WRITE, WIN, LOSE.
- start, in any state: latch secret, guess_num=0, clear win/lose/exact/partial, go to READY next cycle. start has priority over a simultaneous check_req, which is then dropped with no ack and no rej.
- READY + check_req:
  - If any guess peg is 0 or > NUM_COLORS: check_rej pulses and the FSM stays in READY.
  - Otherwise: latch guess, pulse check_ack, go to EXACT; busy=1 from the next cycle.
- check_req outside READY is ignored (no ack, no rej).
- EXACT: NUM_PEGS cycles. Peg counter p=0..NUM_PEGS-1 adds 1 to exact when guess[p]==secret[p].
- COUNT: NUM_COLORS cycles. Colour c=1..NUM_COLORS adds min(count of c in guess, count of c in secret) to total. On leaving COUNT, partial = total - exact. Accumulators are 3 bits; the maximum value is NUM_PEGS, so they never overflow.
- WRITE: 1 cycle. hist_we=1, hist_waddr=guess_num, hist_wdata={partial,exact,guess}, score_vld=1.
- Next state after WRITE:
  - exact==NUM_PEGS → WIN (win=1).
  - else guess_num==MAX_GUESSES-1 → LOSE (lose=1).
  - else guess_num+1, READY.
- guess_num never wraps; WIN and LOSE leave only via start or reset.
- Latency: check_ack (cycle 0) to hist_we/score_vld at cycle NUM_PEGS+NUM_COLORS+1 = 11 with defaults; busy is high cycles 1..11.
- The next check_req is accepted no earlier than cycle 12.
- Reset mid-scoring aborts immediately; no history write occurs.
- game_active = state ∈ {READY, EXACT, COUNT, WRITE}.

Optional Feature:
- Macro MM_REJECT_REPEAT_EN.
- Defined:
  - A register stores the last accepted guess plus a valid bit; the valid bit clears on start and reset.
  - A READY check_req whose guess equals the stored guess while the valid bit is set gets check_rej, with no state change.
- Undefined: repeated guesses are accepted and scored normally.

Decomposition:
- Shared package mm_pkg holds:
  - Constants: NUM_PEGS, COLOR_W, NUM_COLORS, MAX_GUESSES, COLOR_BLANK=0.
  - FSM state encoding.
  - History word field offsets (GUESS_LSB=0, EXACT_LSB=12, PARTIAL_LSB=15).
- One sub-module, mm_color_count: combinational count of occurrences of colour c in a packed peg vector. Instantiated twice, once for guess and once for secret.

Test Plan:
- Secret 001_010_011_100, guess 001_010_011_100 → ack; 11 cycles later hist_we, row 0, exact=4, partial=0; win=1; further check_req ignored.
- Secret 001_010_011_100, guess 100_011_010_001 → exact=0, partial=4; guess_num goes 0→1; state READY.
- Secret 001_001_010_010, guess 010_001_011_011 → exact=1, partial=1.
- Guess containing peg 000, or 111 with NUM_COLORS=6 → check_rej one cycle; no ack, no hist_we; guess_num unchanged.
- Six wrong guesses → rows 0..5 written in order; lose=1 after the 6th write; start → guess_num=0, lose=0, READY.
- Reset asserted at cycle 5 of scoring → all outputs 0, IDLE, no hist_we. Also: start and check_req in the same cycle → restart only, no ack. With MM_REJECT_REPEAT_EN defined, the same guess submitted twice → second gets check_rej.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared constants, FSM encoding and peg helpers for the Mastermind round controller.
package mm_pkg;

   localparam int unsigned NUM_PEGS    = 4;
   localparam int unsigned COLOR_W     = 3;
   localparam int unsigned NUM_COLORS  = 6;
   localparam int unsigned MAX_GUESSES = 6;
   localparam int unsigned CNT_W       = 3;
   localparam int unsigned PEG_VEC_W   = NUM_PEGS * COLOR_W;

   localparam logic [COLOR_W-1:0] COLOR_BLANK = '0;
   localparam logic [COLOR_W-1:0] COLOR_MAX   = COLOR_W'(NUM_COLORS);

   // History word layout: {partial, exact, guess}
   localparam int unsigned GUESS_LSB   = 0;
   localparam int unsigned EXACT_LSB   = GUESS_LSB + PEG_VEC_W;
   localparam int unsigned PARTIAL_LSB = EXACT_LSB + CNT_W;
   localparam int unsigned HIST_W      = PARTIAL_LSB + CNT_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READY,
      ST_EXACT,
      ST_COUNT,
      ST_WRITE,
      ST_WIN,
      ST_LOSE
   } state_t;

   function automatic logic [COLOR_W-1:0] peg_at(input logic [PEG_VEC_W-1:0] v,
                                                 input logic [2:0] i);
      return v[i*COLOR_W +: COLOR_W];
   endfunction

   function automatic logic pegs_legal(input logic [PEG_VEC_W-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int unsigned i = 0; i < NUM_PEGS; i++) begin
         if (v[i*COLOR_W +: COLOR_W] == COLOR_BLANK || v[i*COLOR_W +: COLOR_W] > COLOR_MAX)
            ok = 1'b0;
      end
      return ok;
   endfunction

   function automatic logic [CNT_W-1:0] cnt_min(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/mm_color_count.sv
// Combinational count of how many pegs in a packed peg vector carry a given colour.
module mm_color_count
   import mm_pkg::*;
(
   input  logic [PEG_VEC_W-1:0] pegs,
   input  logic [COLOR_W-1:0]   color,
   output logic [CNT_W-1:0]     count
);

   always_comb begin
      count = '0;
      for (int unsigned i = 0; i < NUM_PEGS; i++) begin
         if (pegs[i*COLOR_W +: COLOR_W] == color)
            count = count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mastermind_round_ctrl.sv
// Mastermind round sequencer: validates, scores and records guesses, tracks win/lose.
// Optional MM_REJECT_REPEAT_EN: reject a guess identical to the last accepted one.
module mastermind_round_ctrl
   import mm_pkg::*;
(
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 start,
   input  logic [PEG_VEC_W-1:0] secret,
   input  logic [PEG_VEC_W-1:0] guess,
   input  logic                 check_req,
   output logic                 check_ack,
   output logic                 check_rej,
   output logic                 busy,
   output logic [2:0]           guess_num,
   output logic [CNT_W-1:0]     exact_cnt,
   output logic [CNT_W-1:0]     partial_cnt,
   output logic                 score_vld,
   output logic                 hist_we,
   output logic [2:0]           hist_waddr,
   output logic [HIST_W-1:0]    hist_wdata,
   output logic                 game_active,
   output logic                 win,
   output logic                 lose
);

   state_t               state;
   logic [PEG_VEC_W-1:0] secret_q;
   logic [PEG_VEC_W-1:0] guess_q;
   logic [2:0]           idx;
   logic [CNT_W-1:0]     exact_acc;
   logic [CNT_W-1:0]     total_acc;
   logic [CNT_W-1:0]     partial_acc;
   logic [CNT_W-1:0]     cnt_g;
   logic [CNT_W-1:0]     cnt_s;
   logic [CNT_W-1:0]     matched;
   logic [COLOR_W-1:0]   cur_color;
   logic                 rej_cond;

`ifdef MM_REJECT_REPEAT_EN
   logic [PEG_VEC_W-1:0] last_guess;
   logic                 last_vld;
`endif

   mm_color_count u_cnt_guess (.pegs(guess_q),  .color(cur_color), .count(cnt_g));
   mm_color_count u_cnt_secret(.pegs(secret_q), .color(cur_color), .count(cnt_s));

   always_comb begin
      cur_color = COLOR_W'(idx) + COLOR_W'(1);
      matched   = cnt_min(cnt_g, cnt_s);
`ifdef MM_REJECT_REPEAT_EN
      rej_cond  = !pegs_legal(guess) || (last_vld && (guess == last_guess));
`else
      rej_cond  = !pegs_legal(guess);
`endif
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state       <= ST_IDLE;
         secret_q    <= '0;
         guess_q     <= '0;
         idx         <= '0;
         exact_acc   <= '0;
         total_acc   <= '0;
         partial_acc <= '0;
         check_ack   <= '0;
         check_rej   <= '0;
         busy        <= '0;
         guess_num   <= '0;
         exact_cnt   <= '0;
         partial_cnt <= '0;
         score_vld   <= '0;
         hist_we     <= '0;
         hist_waddr  <= '0;
         hist_wdata  <= '0;
         game_active <= '0;
         win         <= '0;
         lose        <= '0;
`ifdef MM_REJECT_REPEAT_EN
         last_guess  <= '0;
         last_vld    <= '0;
`endif
      end else begin
         check_ack <= '0;
         check_rej <= '0;
         score_vld <= '0;
         hist_we   <= '0;
         busy      <= (state == ST_EXACT) || (state == ST_COUNT) || (state == ST_WRITE);
         // start wins over everything, including a same-cycle check_req
         if (start) begin
            secret_q    <= secret;
            guess_num   <= '0;
            win         <= '0;
            lose        <= '0;
            exact_cnt   <= '0;
            partial_cnt <= '0;
            busy        <= '0;
            game_active <= 1'b1;
            state       <= ST_READY;
`ifdef MM_REJECT_REPEAT_EN
            last_vld    <= '0;
`endif
         end else begin
            case (state)
               ST_READY: begin
                  if (check_req) begin
                     if (rej_cond) begin
                        check_rej <= 1'b1;
                     end else begin
                        guess_q   <= guess;
                        check_ack <= 1'b1;
                        exact_acc <= '0;
                        total_acc <= '0;
                        idx       <= '0;
                        state     <= ST_EXACT;
`ifdef MM_REJECT_REPEAT_EN
                        last_guess <= guess;
                        last_vld   <= 1'b1;
`endif
                     end
                  end
               end
               ST_EXACT: begin
                  if (peg_at(guess_q, idx) == peg_at(secret_q, idx))
                     exact_acc <= exact_acc + CNT_W'(1);
                  if (idx == 3'(NUM_PEGS - 1)) begin
                     idx   <= '0;
                     state <= ST_COUNT;
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end
               ST_COUNT: begin
                  total_acc <= total_acc + matched;
                  // last colour folds its own match into partial directly
                  if (idx == 3'(NUM_COLORS - 1)) begin
                     partial_acc <= total_acc + matched - exact_acc;
                     state       <= ST_WRITE;
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end
               ST_WRITE: begin
                  hist_we     <= 1'b1;
                  score_vld   <= 1'b1;
                  hist_waddr  <= guess_num;
                  hist_wdata  <= {partial_acc, exact_acc, guess_q};
                  exact_cnt   <= exact_acc;
                  partial_cnt <= partial_acc;
                  if (exact_acc == CNT_W'(NUM_PEGS)) begin
                     win         <= 1'b1;
                     game_active <= 1'b0;
                     state       <= ST_WIN;
                  end else if (guess_num == 3'(MAX_GUESSES - 1)) begin
                     lose        <= 1'b1;
                     game_active <= 1'b0;
                     state       <= ST_LOSE;
                  end else begin
                     guess_num <= guess_num + 3'd1;
                     state     <= ST_READY;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mastermind_round_ctrl.sv
// Self-checking bench for mastermind_round_ctrl: scoring model plus directed game scenarios.
module tb_mastermind_round_ctrl;

   localparam int LAT = 11;
   localparam int P_IDLE = 0, P_READY = 1, P_SCORE = 2, P_WON = 3, P_LOST = 4;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        start = 1'b0;
   logic        check_req = 1'b0;
   logic [11:0] secret = '0;
   logic [11:0] guess = '0;
   logic        check_ack, check_rej, busy, score_vld, hist_we;
   logic        game_active, win, lose;
   logic [2:0]  guess_num, exact_cnt, partial_cnt, hist_waddr;
   logic [17:0] hist_wdata;

   int checks = 0;
   int errors = 0;

   mastermind_round_ctrl dut (
      .Clk(Clk), .Reset(Reset), .start(start), .secret(secret), .guess(guess),
      .check_req(check_req), .check_ack(check_ack), .check_rej(check_rej), .busy(busy),
      .guess_num(guess_num), .exact_cnt(exact_cnt), .partial_cnt(partial_cnt),
      .score_vld(score_vld), .hist_we(hist_we), .hist_waddr(hist_waddr),
      .hist_wdata(hist_wdata), .game_active(game_active), .win(win), .lose(lose)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- scoring rules ----------------
   function automatic logic [2:0] pg(input logic [11:0] v, input int i);
      return v[i*3 +: 3];
   endfunction

   function automatic bit legal(input logic [11:0] v);
      for (int i = 0; i < 4; i++)
         if (pg(v, i) == 3'd0 || pg(v, i) > 3'd6) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int exact_of(input logic [11:0] s, input logic [11:0] g);
      int n = 0;
      for (int i = 0; i < 4; i++) if (pg(s, i) == pg(g, i)) n++;
      return n;
   endfunction

   // Pair each non-exact guess peg with a still-unused non-exact secret peg of the same colour
   function automatic int partial_of(input logic [11:0] s, input logic [11:0] g);
      bit us[4];
      bit ug[4];
      bit found;
      int n = 0;
      for (int i = 0; i < 4; i++) begin
         us[i] = (pg(s, i) == pg(g, i));
         ug[i] = us[i];
      end
      for (int i = 0; i < 4; i++) begin
         if (!ug[i]) begin
            found = 1'b0;
            for (int j = 0; j < 4; j++) begin
               if (!found && !us[j] && pg(g, i) == pg(s, j)) begin
                  us[j] = 1'b1;
                  found = 1'b1;
                  n++;
               end
            end
         end
      end
      return n;
   endfunction

   // ---------------- reference model ----------------
   int          phase = P_IDLE;
   int          timer = 0;
   logic [11:0] m_secret = '0, m_guess = '0, m_last = '0;
   logic        m_lastv = 1'b0;
   logic        m_ack = 1'b0, m_rej = 1'b0, m_we = 1'b0, m_vld = 1'b0, m_busy = 1'b0;
   logic        m_ga = 1'b0, m_win = 1'b0, m_lose = 1'b0;
   logic [2:0]  m_gnum = '0, m_exact = '0, m_partial = '0, m_waddr = '0;
   logic [17:0] m_wdata = '0;
   logic        m_rep;

`ifdef MM_REJECT_REPEAT_EN
   assign m_rep = m_lastv && (guess == m_last);
`else
   assign m_rep = 1'b0;
`endif

   always @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         phase <= P_IDLE; timer <= 0; m_secret <= '0; m_guess <= '0; m_last <= '0;
         m_lastv <= 1'b0; m_ack <= 1'b0; m_rej <= 1'b0; m_we <= 1'b0; m_vld <= 1'b0;
         m_busy <= 1'b0; m_ga <= 1'b0; m_win <= 1'b0; m_lose <= 1'b0; m_gnum <= '0;
         m_exact <= '0; m_partial <= '0; m_waddr <= '0; m_wdata <= '0;
      end else begin
         m_ack <= 1'b0; m_rej <= 1'b0; m_we <= 1'b0; m_vld <= 1'b0;
         m_busy <= (phase == P_SCORE);
         if (start) begin
            m_secret <= secret; m_gnum <= '0; m_win <= 1'b0; m_lose <= 1'b0;
            m_exact <= '0; m_partial <= '0; m_busy <= 1'b0; m_ga <= 1'b1;
            m_lastv <= 1'b0; phase <= P_READY;
         end else if (phase == P_READY) begin
            if (check_req) begin
               if (!legal(guess) || m_rep) m_rej <= 1'b1;
               else begin
                  m_ack <= 1'b1; m_guess <= guess; m_last <= guess; m_lastv <= 1'b1;
                  timer <= 1; phase <= P_SCORE;
               end
            end
         end else if (phase == P_SCORE) begin
            if (timer == LAT) begin
               m_we <= 1'b1; m_vld <= 1'b1; m_waddr <= m_gnum;
               m_exact <= 3'(exact_of(m_secret, m_guess));
               m_partial <= 3'(partial_of(m_secret, m_guess));
               m_wdata <= {3'(partial_of(m_secret, m_guess)), 3'(exact_of(m_secret, m_guess)), m_guess};
               if (exact_of(m_secret, m_guess) == 4) begin
                  m_win <= 1'b1; m_ga <= 1'b0; phase <= P_WON;
               end else if (m_gnum == 3'd5) begin
                  m_lose <= 1'b1; m_ga <= 1'b0; phase <= P_LOST;
               end else begin
                  m_gnum <= m_gnum + 3'd1; phase <= P_READY;
               end
            end else begin
               timer <= timer + 1;
            end
         end
      end
   end

   always @(negedge Clk) begin
      check("check_ack", 32'(check_ack), 32'(m_ack));
      check("check_rej", 32'(check_rej), 32'(m_rej));
      check("busy", 32'(busy), 32'(m_busy));
      check("hist_we", 32'(hist_we), 32'(m_we));
      check("score_vld", 32'(score_vld), 32'(m_vld));
      check("guess_num", 32'(guess_num), 32'(m_gnum));
      check("exact_cnt", 32'(exact_cnt), 32'(m_exact));
      check("partial_cnt", 32'(partial_cnt), 32'(m_partial));
      check("game_active", 32'(game_active), 32'(m_ga));
      check("win", 32'(win), 32'(m_win));
      check("lose", 32'(lose), 32'(m_lose));
      if (m_we) begin
         check("hist_waddr", 32'(hist_waddr), 32'(m_waddr));
         check("hist_wdata", 32'(hist_wdata), 32'(m_wdata));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(negedge Clk);
   endtask

   task automatic do_start(input logic [11:0] s);
      start = 1'b1; secret = s;
      tick();
      start = 1'b0;
   endtask

   task automatic do_submit(input logic [11:0] g);
      guess = g; check_req = 1'b1;
      tick();
      check_req = 1'b0;
   endtask

   task automatic wait_write(output int n);
      n = 0;
      while (!hist_we && n < 30) begin
         tick();
         n++;
      end
   endtask

   localparam logic [11:0] S1234 = 12'b001_010_011_100;
   logic [11:0] wrong [6];
   int n;

   initial begin
      wrong[0] = 12'b101_101_101_101;
      wrong[1] = 12'b110_110_110_110;
      wrong[2] = 12'b001_001_001_001;
      wrong[3] = 12'b100_011_010_001;
      wrong[4] = 12'b010_001_100_011;
      wrong[5] = 12'b110_101_011_100;

      #1 Reset = 1'b0;
      repeat (3) tick();
      check("rst_active", 32'(game_active), 32'd0);
      check("rst_gnum", 32'(guess_num), 32'd0);
      Reset = 1'b1;
      tick();

      do_submit(S1234);
      check("idle_ignore", 32'(check_ack), 32'd0);

      // exact hit: win on first guess
      do_start(S1234);
      check("start_ready", 32'(game_active), 32'd1);
      do_submit(S1234);
      check("win_ack", 32'(check_ack), 32'd1);
      wait_write(n);
      check("win_latency", 32'(n), 32'd11);
      check("win_row", 32'(hist_waddr), 32'd0);
      check("win_data", 32'(hist_wdata), 32'({3'd0, 3'd4, S1234}));
      check("win_flag", 32'(win), 32'd1);
      tick();
      do_submit(S1234);
      check("won_ignore", 32'(check_ack | check_rej), 32'd0);

      // all colours right, all misplaced
      do_start(S1234);
      do_submit(12'b100_011_010_001);
      wait_write(n);
      check("perm_latency", 32'(n), 32'd11);
      check("perm_data", 32'(hist_wdata), 32'({3'd4, 3'd0, 12'b100_011_010_001}));
      check("perm_gnum", 32'(guess_num), 32'd1);

      // illegal pegs rejected, guess_num untouched
      do_submit(12'b001_000_011_100);
      check("rej_blank", 32'(check_rej), 32'd1);
      do_submit(12'b111_001_010_011);
      check("rej_seven", 32'(check_rej), 32'd1);
      check("rej_gnum", 32'(guess_num), 32'd1);

      // duplicates in both secret and guess
      do_start(12'b001_001_010_010);
      do_submit(12'b010_001_011_011);
      wait_write(n);
      check("dup_exact", 32'(exact_cnt), 32'd1);
      check("dup_partial", 32'(partial_cnt), 32'd1);

      // six misses -> lose
      do_start(S1234);
      for (int i = 0; i < 6; i++) begin
         do_submit(wrong[i]);
         wait_write(n);
         check("miss_row", 32'(hist_waddr), 32'(i));
      end
      check("lose_flag", 32'(lose), 32'd1);
      tick();
      do_submit(S1234);
      check("lost_ignore", 32'(check_ack), 32'd0);
      do_start(S1234);
      check("restart_gnum", 32'(guess_num), 32'd0);
      check("restart_lose", 32'(lose), 32'd0);
      check("restart_active", 32'(game_active), 32'd1);

      // reset in the middle of scoring
      do_submit(wrong[0]);
      repeat (5) tick();
      #2 Reset = 1'b0;
      tick();
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_we", 32'(hist_we), 32'd0);
      tick();
      Reset = 1'b1;
      repeat (14) tick();

      // start and check_req together: restart only
      do_start(S1234);
      start = 1'b1; secret = S1234; guess = wrong[1]; check_req = 1'b1;
      tick();
      start = 1'b0; check_req = 1'b0;
      check("start_prio", 32'(check_ack | check_rej), 32'd0);
      check("start_prio_ready", 32'(game_active), 32'd1);

      // same guess submitted twice
      do_submit(12'b010_010_010_010);
      wait_write(n);
      check("rep_first", 32'(hist_wdata), 32'({3'd0, 3'd1, 12'b010_010_010_010}));
      do_submit(12'b010_010_010_010);
`ifdef MM_REJECT_REPEAT_EN
      check("rep_second", 32'(check_rej), 32'd1);
`else
      check("rep_second", 32'(check_ack), 32'd1);
`endif
      repeat (14) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
